// File: rtl/cd6_div_pkg.sv
// Shared constants and types for the cd6 sequential restoring divider.
package cd6_div_pkg;

  localparam int DEF_DW = 12;
  localparam int DEF_VW = 4;
  localparam int DEF_QW = 8;
  localparam int CNT_W  = $clog2(DEF_QW);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/cd6_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module cd6_div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] p,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] p_next,
  output logic          q_bit
);

  logic [VW:0] t;

  // A kept remainder is always below the divisor, so it fits back into VW bits.
  always_comb begin
    t      = {p, bit_in};
    q_bit  = (t >= {1'b0, divisor});
    p_next = q_bit ? VW'(t - {1'b0, divisor}) : t[VW-1:0];
  end

endmodule

// File: rtl/cd6_seq_divider.sv
// Sequential restoring divider: DW-bit product / VW-bit operand -> QW-bit quotient, VW-bit remainder.
// Optional feature macro CD6_DIV_SELFCHECK_EN adds a registered chk_err multiply-back check.
import cd6_div_pkg::*;

module cd6_seq_divider #(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW,
  parameter int QW = DEF_QW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          ovf,
  output logic          dbz
`ifdef CD6_DIV_SELFCHECK_EN
  ,
  output logic          chk_err
`endif
);

  div_state_t state, next_state;

  logic [VW-1:0]    divisor_r;
  logic [QW-1:0]    lo_sh;
  logic [VW-1:0]    p_r;
  logic [CNT_W-1:0] cnt;
  logic [VW-1:0]    p_next;
  logic             q_bit;
  logic [VW-1:0]    hi;
  logic             last_step;

  assign hi        = dividend[DW-1:QW];
  assign last_step = (cnt == CNT_W'(QW - 1));

  cd6_div_step #(.VW(VW)) u_step (
    .p       (p_r),
    .bit_in  (lo_sh[QW-1]),
    .divisor (divisor_r),
    .p_next  (p_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Zero divisor and oversized quotient both skip the iteration and finish immediately.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (divisor == '0 || hi >= divisor) next_state = DONE;
          else                                next_state = CALC;
        end
      end
      CALC: if (last_step) next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef CD6_DIV_SELFCHECK_EN
  logic [DW-1:0] dividend_r;
  logic [QW-1:0] q_final;
  logic          chk_next;

  always_comb begin
    q_final  = {quotient[QW-2:0], q_bit};
    chk_next = (({{VW{1'b0}}, q_final} * {{QW{1'b0}}, divisor_r})
               + {{QW{1'b0}}, p_next}) != dividend_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_r <= '0;
      chk_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dividend_r <= dividend;
          chk_err    <= 1'b0;
        end
        CALC: if (last_step) chk_err <= chk_next;
        DONE: if (out_ready) chk_err <= 1'b0;
        default: chk_err <= 1'b0;
      endcase
    end
  end
`endif

  // Quotient bits shift in at the LSB; eight steps fully overwrite any stale contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor_r <= '0;
      lo_sh     <= '0;
      p_r       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          divisor_r <= divisor;
          lo_sh     <= dividend[QW-1:0];
          p_r       <= hi;
          cnt       <= '0;
          if (divisor == '0) begin
            dbz       <= 1'b1;
            ovf       <= 1'b0;
            quotient  <= '1;
            remainder <= dividend[VW-1:0];
          end else if (hi >= divisor) begin
            dbz       <= 1'b0;
            ovf       <= 1'b1;
            quotient  <= '1;
            remainder <= '0;
          end else begin
            dbz <= 1'b0;
            ovf <= 1'b0;
          end
        end
        CALC: begin
          p_r      <= p_next;
          lo_sh    <= {lo_sh[QW-2:0], 1'b0};
          quotient <= {quotient[QW-2:0], q_bit};
          cnt      <= cnt + 1'b1;
          if (last_step) remainder <= p_next;
        end
        DONE: if (out_ready) begin
          ovf <= 1'b0;
          dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cd6_seq_divider.sv
// Self-checking bench for cd6_seq_divider: arithmetic reference model plus directed vectors.
// Honours CD6_DIV_SELFCHECK_EN to connect and check chk_err.
module tb_cd6_seq_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] dividend;
  logic [3:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [3:0]  remainder;
  logic        ovf;
  logic        dbz;
`ifdef CD6_DIV_SELFCHECK_EN
  logic        chk_err;
`endif

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       ovf;
    logic       dbz;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  cd6_seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
`ifdef CD6_DIV_SELFCHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // Plain unsigned arithmetic: the true quotient decides overflow.
  function automatic exp_t model(input logic [11:0] dd, input logic [3:0] dv);
    exp_t e;
    int unsigned tq;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (dv == 0) begin
      e.dbz = 1'b1;
      e.q   = 8'hFF;
      e.r   = dd[3:0];
    end else begin
      tq = int'(dd) / int'(dv);
      if (tq >= 256) begin
        e.ovf = 1'b1;
        e.q   = 8'hFF;
        e.r   = 4'd0;
      end else begin
        e.q = 8'(tq);
        e.r = 4'(int'(dd) % int'(dv));
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        check("model_quotient", quotient, exp_q[0].q);
        check("model_remainder", remainder, exp_q[0].r);
        check("model_ovf", ovf, exp_q[0].ovf);
        check("model_dbz", dbz, exp_q[0].dbz);
`ifdef CD6_DIV_SELFCHECK_EN
        check("model_chk_err", chk_err, 32'd0);
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
      check("in_ready_low_in_done", in_ready, 32'd0);
    end
  end

  task automatic checkOutput(input logic [7:0] q, input logic [3:0] r,
                             input logic o, input logic z);
    check("lit_quotient", quotient, q);
    check("lit_remainder", remainder, r);
    check("lit_ovf", ovf, o);
    check("lit_dbz", dbz, z);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
  task automatic applyStimulus(input logic [11:0] dd, input logic [3:0] dv,
                               input logic [7:0] q, input logic [3:0] r,
                               input logic o, input logic z,
                               input int lat_req, input int hold);
    int lat;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    dividend  = dd;
    divisor   = dv;
    check("in_ready_idle", in_ready, 32'd1);
    @(posedge clk);
    exp_q.push_back(model(dd, dv));
    #1;
    in_valid = 1'b0;
    dividend = 12'(~dd);
    divisor  = 4'(dv + 4'd5);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, lat_req);
    checkOutput(q, r, o, z);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = 12'd100 + 12'(i);
      divisor  = 4'd3;
      @(posedge clk);
      #1;
      check("held_out_valid", out_valid, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", out_valid, 32'd0);
    check("release_in_ready", in_ready, 32'd1);
    check("release_ovf", ovf, 32'd0);
    check("release_dbz", dbz, 32'd0);
  endtask

  initial begin
    int bad;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    #3;
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_ovf", ovf, 32'd0);
    check("rst_dbz", dbz, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(12'd2600, 4'd13, 8'd200, 4'd0,  1'b0, 1'b0, 8, 0);
    applyStimulus(12'd1000, 4'd7,  8'd142, 4'd6,  1'b0, 1'b0, 8, 0);
    applyStimulus(12'd3839, 4'd15, 8'd255, 4'd14, 1'b0, 1'b0, 8, 0);
    applyStimulus(12'd4095, 4'd15, 8'd255, 4'd0,  1'b1, 1'b0, 0, 0);
    applyStimulus(12'h5A7,  4'd0,  8'd255, 4'd7,  1'b0, 1'b1, 0, 0);
    applyStimulus(12'd16,   4'd3,  8'd5,   4'd1,  1'b0, 1'b0, 8, 0);
    applyStimulus(12'd255,  4'd1,  8'd255, 4'd0,  1'b0, 1'b0, 8, 0);
    applyStimulus(12'd1000, 4'd7,  8'd142, 4'd6,  1'b0, 1'b0, 8, 5);
    applyStimulus(12'd0,    4'd0,  8'd255, 4'd0,  1'b0, 1'b1, 0, 3);

    // Abort a division partway through the iteration.
    in_valid = 1'b1;
    dividend = 12'd2600;
    divisor  = 4'd13;
    @(posedge clk);
    exp_q.push_back(model(12'd2600, 4'd13));
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", out_valid, 32'd0);
    check("midrst_in_ready", in_ready, 32'd1);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_ovf", ovf, 32'd0);
    check("midrst_dbz", dbz, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) bad++;
    end
    check("no_result_after_reset", bad, 32'd0);
    applyStimulus(12'd2600, 4'd13, 8'd200, 4'd0, 1'b0, 1'b0, 8, 0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
